// File: rtl/wb_bus_decoder_pkg.sv
// Shared state encoding and error-cause codes for the Wishbone slave-side decoder.
package wb_bus_decoder_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_WAIT = 2'd1,
    ST_ERR  = 2'd2
  } dec_state_e;

  localparam logic [1:0] CAUSE_NONE    = 2'b00;
  localparam logic [1:0] CAUSE_DECODE  = 2'b01;
  localparam logic [1:0] CAUSE_TIMEOUT = 2'b10;

endpackage

// File: rtl/wb_addr_match.sv
// Combinational base/mask address compare; lowest-index slave wins on overlap.
// Latency: 0 cycles. No flow control.
module wb_addr_match #(
  parameter int unsigned        S        = 4,
  parameter int unsigned        Aw       = 32,
  parameter logic [S*Aw-1:0]    BASE_ALL = '0,
  parameter logic [S*Aw-1:0]    MASK_ALL = '0
) (
  input  logic [Aw-1:0] addr_i,
  output logic [S-1:0]  sel_o,
  output logic          hit_o
);

  always_comb begin
    sel_o = '0;
    hit_o = 1'b0;
    for (int i = 0; i < int'(S); i++) begin
      if (!hit_o &&
          ((addr_i & MASK_ALL[i*Aw +: Aw]) == (BASE_ALL[i*Aw +: Aw] & MASK_ALL[i*Aw +: Aw]))) begin
        sel_o[i] = 1'b1;
        hit_o    = 1'b1;
      end
    end
  end

endmodule

// File: rtl/wb_bus_addr_decoder.sv
// Wishbone slave select decoder plus bus watchdog (timeout path under WB_DECODE_TIMEOUT_EN).
// Select is registered one cycle after the request; errors are a single-cycle err_o pulse.
module wb_bus_addr_decoder
  import wb_bus_decoder_pkg::*;
#(
  parameter int unsigned     S         = 4,
  parameter int unsigned     Aw        = 32,
  parameter logic [S*Aw-1:0] BASE_ALL  = {S*Aw{1'b0}},
  parameter logic [S*Aw-1:0] MASK_ALL  = {S*Aw{1'b0}},
  parameter int unsigned     TO_CYCLES = 255
) (
  input  logic          clk,
  input  logic          reset,
  input  logic [Aw-1:0] m_grant_addr,
  input  logic          cyc_i,
  input  logic          stb_i,
  input  logic          ack_i,
  input  logic          err_i,
  input  logic          rty_i,
  output logic [S-1:0]  s_sel_one_hot,
  output logic          err_o,
  output logic [Aw-1:0] err_addr_o,
  output logic [1:0]    err_cause_o
);

  logic [S-1:0]  hit_sel;
  logic          hit;
  logic          resp;

  dec_state_e    state_q;
  logic [S-1:0]  sel_q;
  logic          err_q;
  logic [Aw-1:0] err_addr_q;
  logic [1:0]    err_cause_q;

  wb_addr_match #(
    .S        (S),
    .Aw       (Aw),
    .BASE_ALL (BASE_ALL),
    .MASK_ALL (MASK_ALL)
  ) u_match (
    .addr_i (m_grant_addr),
    .sel_o  (hit_sel),
    .hit_o  (hit)
  );

  assign resp = ack_i | err_i | rty_i;

`ifdef WB_DECODE_TIMEOUT_EN
  localparam int unsigned CW = $clog2(TO_CYCLES + 1);

  logic [CW-1:0] cnt_q;
  logic [CW-1:0] cnt_d;
  logic          timeout;

  // Saturating increment; the compare is on the post-increment value so the
  // select is held for exactly TO_CYCLES WAIT cycles.
  assign cnt_d   = (cnt_q == CW'(TO_CYCLES)) ? cnt_q : cnt_q + 1'b1;
  assign timeout = (cnt_d == CW'(TO_CYCLES));
`else
  if (TO_CYCLES == 0) begin : g_to_cycles_unused
  end
`endif

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q     <= ST_IDLE;
      sel_q       <= '0;
      err_q       <= 1'b0;
      err_addr_q  <= '0;
      err_cause_q <= CAUSE_NONE;
`ifdef WB_DECODE_TIMEOUT_EN
      cnt_q       <= '0;
`endif
    end else begin
      err_q <= 1'b0;
      case (state_q)
        ST_IDLE: begin
          if (cyc_i && stb_i) begin
            if (hit) begin
              sel_q   <= hit_sel;
              state_q <= ST_WAIT;
`ifdef WB_DECODE_TIMEOUT_EN
              cnt_q   <= '0;
`endif
            end else begin
              err_addr_q  <= m_grant_addr;
              err_cause_q <= CAUSE_DECODE;
              err_q       <= 1'b1;
              state_q     <= ST_ERR;
            end
          end
        end
        ST_WAIT: begin
          // Response beats the watchdog; an abort never raises an error.
          if (resp || !cyc_i) begin
            sel_q   <= '0;
            state_q <= ST_IDLE;
          end
`ifdef WB_DECODE_TIMEOUT_EN
          else if (timeout) begin
            sel_q       <= '0;
            err_addr_q  <= m_grant_addr;
            err_cause_q <= CAUSE_TIMEOUT;
            err_q       <= 1'b1;
            state_q     <= ST_ERR;
          end else begin
            cnt_q <= cnt_d;
          end
`endif
        end
        ST_ERR: begin
          state_q <= ST_IDLE;
        end
        default: begin
          sel_q   <= '0;
          state_q <= ST_IDLE;
        end
      endcase
    end
  end

  assign s_sel_one_hot = sel_q;
  assign err_o         = err_q;
  assign err_addr_o    = err_addr_q;
  assign err_cause_o   = err_cause_q;

endmodule

// File: tb/tb_wb_bus_addr_decoder.sv
// Directed bench for wb_bus_addr_decoder: decode table plus hand-written multi-cycle sequences.
module tb_wb_bus_addr_decoder;

  localparam int unsigned S  = 4;
  localparam int unsigned Aw = 32;
  localparam int unsigned TO = 8;
  localparam logic [S*Aw-1:0] BASES = {32'h3000_0000, 32'h2000_0000, 32'h1000_0000, 32'h0000_0000};
  localparam logic [S*Aw-1:0] MASKS = {4{32'hF000_0000}};

  logic          clk;
  logic          rst_n;
  logic [Aw-1:0] addr;
  logic          cyc, stb, ack, serr, rty;
  logic [S-1:0]  sel;
  logic          err;
  logic [Aw-1:0] err_addr;
  logic [1:0]    err_cause;

  int checks;
  int failures;

  logic [Aw-1:0] exp_ea;
  logic [1:0]    exp_ec;

  typedef struct {
    logic [31:0] addr;
    logic [3:0]  sel;
    logic        miss;
  } vec_t;

  vec_t vecs [7];

  wb_bus_addr_decoder #(
    .S         (S),
    .Aw        (Aw),
    .BASE_ALL  (BASES),
    .MASK_ALL  (MASKS),
    .TO_CYCLES (TO)
  ) dut (
    .clk           (clk),
    .reset         (rst_n),
    .m_grant_addr  (addr),
    .cyc_i         (cyc),
    .stb_i         (stb),
    .ack_i         (ack),
    .err_i         (serr),
    .rty_i         (rty),
    .s_sel_one_hot (sel),
    .err_o         (err),
    .err_addr_o    (err_addr),
    .err_cause_o   (err_cause)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h expected=%h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_bus();
    cyc = 1'b0;
    stb = 1'b0;
    ack = 1'b0;
    serr = 1'b0;
    rty = 1'b0;
  endtask

  task automatic request(input logic [31:0] a);
    addr = a;
    cyc  = 1'b1;
    stb  = 1'b1;
  endtask

  task automatic chk_err_regs(input string name);
    chk({name, "_err_addr"}, err_addr, exp_ea);
    chk({name, "_err_cause"}, {30'd0, err_cause}, {30'd0, exp_ec});
  endtask

  initial begin
    checks   = 0;
    failures = 0;
    exp_ea   = '0;
    exp_ec   = 2'b00;

    vecs[0] = '{32'h0000_0004, 4'b0001, 1'b0};
    vecs[1] = '{32'h1234_5678, 4'b0010, 1'b0};
    vecs[2] = '{32'h2000_0010, 4'b0100, 1'b0};
    vecs[3] = '{32'h3FFF_FFFF, 4'b1000, 1'b0};
    vecs[4] = '{32'h5000_0000, 4'b0000, 1'b1};
    vecs[5] = '{32'hF000_0000, 4'b0000, 1'b1};
    vecs[6] = '{32'h4000_0000, 4'b0000, 1'b1};

    // Reset held with a live miss request on the bus: outputs must stay at reset values.
    rst_n = 1'b0;
    idle_bus();
    request(32'h5000_0000);
    step();
    step();
    chk("reset_sel", {28'd0, sel}, 32'd0);
    chk("reset_err", {31'd0, err}, 32'd0);
    chk_err_regs("reset");
    idle_bus();
    addr = '0;
    step();
    rst_n = 1'b1;
    step();

    // Decode table: one-beat transactions, hits acked immediately.
    for (int i = 0; i < 7; i++) begin
      request(vecs[i].addr);
      step();
      chk($sformatf("vec%0d_sel", i), {28'd0, sel}, {28'd0, vecs[i].sel});
      chk($sformatf("vec%0d_err", i), {31'd0, err}, {31'd0, vecs[i].miss});
      if (vecs[i].miss) begin
        exp_ea = vecs[i].addr;
        exp_ec = 2'b01;
        idle_bus();
      end else begin
        ack = 1'b1;
      end
      chk_err_regs($sformatf("vec%0d", i));
      step();
      chk($sformatf("vec%0d_sel_after", i), {28'd0, sel}, 32'd0);
      chk($sformatf("vec%0d_err_after", i), {31'd0, err}, 32'd0);
      idle_bus();
      step();
    end

    // Read acked three cycles after the select appears.
    request(32'h2000_0010);
    for (int k = 1; k <= 4; k++) begin
      step();
      chk($sformatf("rd_sel_c%0d", k), {28'd0, sel}, 32'h4);
      chk($sformatf("rd_err_c%0d", k), {31'd0, err}, 32'd0);
    end
    ack = 1'b1;
    addr = 32'h5000_0000;
    step();
    chk("rd_sel_end", {28'd0, sel}, 32'd0);
    chk("rd_err_end", {31'd0, err}, 32'd0);
    idle_bus();
    step();

    // Unresponsive slave.
    request(32'h1000_0000);
    for (int k = 1; k <= int'(TO); k++) begin
      step();
      chk($sformatf("to_sel_c%0d", k), {28'd0, sel}, 32'h2);
      chk($sformatf("to_err_c%0d", k), {31'd0, err}, 32'd0);
    end
    step();
`ifdef WB_DECODE_TIMEOUT_EN
    exp_ea = 32'h1000_0000;
    exp_ec = 2'b10;
    chk("to_err_pulse", {31'd0, err}, 32'd1);
    chk("to_sel_pulse", {28'd0, sel}, 32'd0);
    chk_err_regs("to");
    idle_bus();
    step();
    chk("to_err_single", {31'd0, err}, 32'd0);
`else
    for (int k = 0; k < 20; k++) begin
      chk($sformatf("hold_sel_c%0d", k), {28'd0, sel}, 32'h2);
      chk($sformatf("hold_err_c%0d", k), {31'd0, err}, 32'd0);
      step();
    end
    chk_err_regs("hold");
    idle_bus();
    step();
    chk("hold_abort_sel", {28'd0, sel}, 32'd0);
    chk("hold_abort_err", {31'd0, err}, 32'd0);
`endif
    step();

    // Ack on the same cycle the watchdog would fire.
    request(32'h1000_0000);
    for (int k = 1; k <= int'(TO); k++) step();
    chk("race_sel_last", {28'd0, sel}, 32'h2);
    ack = 1'b1;
    step();
    chk("race_err", {31'd0, err}, 32'd0);
    chk("race_sel", {28'd0, sel}, 32'd0);
    idle_bus();
    step();
    chk("race_err_late", {31'd0, err}, 32'd0);
    chk_err_regs("race");

    // Master abort in the second WAIT cycle, then an immediate new request.
    request(32'h0000_0100);
    step();
    step();
    chk("abort_sel_w2", {28'd0, sel}, 32'h1);
    idle_bus();
    step();
    chk("abort_sel", {28'd0, sel}, 32'd0);
    chk("abort_err", {31'd0, err}, 32'd0);
    request(32'h3000_0000);
    step();
    chk("abort_new_sel", {28'd0, sel}, 32'h8);
    ack = 1'b1;
    step();
    idle_bus();
    step();
    chk_err_regs("abort");

    // Asynchronous reset in WAIT.
    request(32'h2000_0000);
    step();
    chk("arst_pre_sel", {28'd0, sel}, 32'h4);
    #2;
    rst_n = 1'b0;
    #1;
    exp_ea = '0;
    exp_ec = 2'b00;
    chk("arst_sel", {28'd0, sel}, 32'd0);
    chk("arst_err", {31'd0, err}, 32'd0);
    chk_err_regs("arst");
    idle_bus();
    step();
    chk("arst_err_hold", {31'd0, err}, 32'd0);
    rst_n = 1'b1;
    step();
    request(32'h1000_0040);
    step();
    chk("post_arst_sel", {28'd0, sel}, 32'h2);
    chk("post_arst_err", {31'd0, err}, 32'd0);
    ack = 1'b1;
    step();
    chk("post_arst_sel_end", {28'd0, sel}, 32'd0);
    idle_bus();
    step();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/wb_bus_addr_decoder.md
# wb_bus_addr_decoder

Slave-side address decoder and bus watchdog for the parametrizable Wishbone shared bus. It consumes the granted master address and cycle strobes that the bus exports, and produces the registered one-hot slave select that the bus uses to route `stb` and read data. It also terminates unmapped or unresponsive transactions with a single-cycle error. Its error output is wired as one extra lane of the bus's slave error vector.

## Interface
Parameters:
- `S`, 4, number of slaves; the one-hot select width.
- `Aw`, 32, address width.
- `BASE_ALL`, `{S*Aw{1'b0}}`, packed base addresses; slave i occupies `[i*Aw +: Aw]`.
- `MASK_ALL`, `{S*Aw{1'b0}}`, packed compare masks; slave i hits when `(addr & mask_i) == (base_i & mask_i)`.
- `TO_CYCLES`, 255, WAIT cycles allowed before a timeout; legal range 1..65535.

Ports:
- `clk`  in  1  bus clock.
- `reset`  in  1  asynchronous, active-low reset.
- `m_grant_addr`  in  Aw  address of the granted master.
- `cyc_i`  in  1  granted master `cyc`.
- `stb_i`  in  1  granted master `stb`.
- `ack_i`, `err_i`, `rty_i`  in  1 each  OR of the real slaves' responses.
- `s_sel_one_hot`  out  S  registered slave select.
- `err_o`  out  1  error termination toward the granted master.
- `err_addr_o`  out  Aw  address of the most recent error.
- `err_cause_o`  out  2  cause of the most recent error: 01 = decode miss, 10 = timeout.

## Operation
The decoder is a Moore FSM with three states: IDLE, WAIT and ERR.

- **IDLE**
  - `s_sel_one_hot` is 0.
  - On `cyc_i & stb_i`, compute the hit vector. If slave ranges overlap, the lowest index wins.
  - Any hit: register its one-hot into `s_sel_one_hot`, clear the counter, go to WAIT.
  - No hit: latch the address and cause 01, go to ERR.
- **WAIT**
  - `s_sel_one_hot` is held stable regardless of any address change.
  - `ack_i | err_i | rty_i`: clear the select, go to IDLE. This is a one-beat transaction, and each burst beat is re-decoded.
  - `~cyc_i` (master abort): clear the select, go to IDLE. No error is raised.
  - Counter reaches `TO_CYCLES` with no response: clear the select, latch the address and cause 10, go to ERR.
  - If a response and the timeout occur in the same cycle, the response wins.
- **ERR**
  - `err_o` is 1 for exactly one cycle, with select 0.
  - Always returns to IDLE.
  - If `cyc_i` is low on entry, the error pulse is still issued and is harmless to the master.
- The counter is `$clog2(TO_CYCLES+1)` bits wide. It saturates and never wraps.
- `err_addr_o` and `err_cause_o` are updated only on entry to ERR and hold their value otherwise.

## Timing
- Reset values: state IDLE, `s_sel_one_hot` = 0, `err_o` = 0, `err_addr_o` = 0, `err_cause_o` = 00, counter 0.
- Select latency: the request is sampled at edge N and the select is valid from cycle N+1. The routed `stb` therefore reaches the slave one cycle after the master raises it.
- Decode miss: request at edge N, `err_o` high during cycle N+1, IDLE at N+2.
- Timeout: with the select asserted in cycle N+1, `err_o` is high in cycle N+1+`TO_CYCLES`.
- A slave response sampled at edge K drops the select in cycle K+1. A new request may be accepted at edge K+1.
- Reset asserted mid-operation: immediate return to reset values with no error pulse.

## Configuration
- `WB_DECODE_TIMEOUT_EN` defined: the watchdog counter and the WAIT→ERR timeout path exist.
- Undefined:
  - No counter is present, and `TO_CYCLES` is ignored.
  - WAIT exits only on a slave response or `~cyc_i`.
  - `err_cause_o` can only be 01 or 00.

## Structure
- Package `wb_bus_decoder_pkg` holds:
  - the state encoding (IDLE = 2'd0, WAIT = 2'd1, ERR = 2'd2);
  - the cause constants `CAUSE_NONE` = 2'b00, `CAUSE_DECODE` = 2'b01, `CAUSE_TIMEOUT` = 2'b10.
- Sub-module `wb_addr_match` is purely combinational. It takes the address plus `BASE_ALL`/`MASK_ALL` and outputs the priority-resolved one-hot and a `hit` flag.

## Test plan
All scenarios use S=4, Aw=32, bases 0x0000_0000/0x1000_0000/0x2000_0000/0x3000_0000, every mask 0xF000_0000, TO_CYCLES=8.
- Read at 0x2000_0010, slave acks 3 cycles after the select appears -> `s_sel_one_hot` = 4'b0100 from edge+1 through the ack cycle, 0 the next cycle, `err_o` never set.
- Access to 0x5000_0000 -> select stays 0, `err_o` = 1 for exactly one cycle at edge+1, `err_addr_o` = 0x5000_0000, `err_cause_o` = 01.
- Access to 0x1000_0000 with no ack -> select 4'b0010 for 8 cycles, then `err_o` for one cycle, `err_cause_o` = 10; with the macro undefined, the select holds indefinitely.
- Ack arriving on the same cycle the counter hits 8 -> no `err_o`, return to IDLE, cause registers unchanged.
- `cyc_i` dropped in the 2nd WAIT cycle -> select 0 next cycle, no error; an immediate new request to 0x3000_0000 gives select 4'b1000.
- `reset` driven low in WAIT -> all outputs 0 asynchronously; after release, a request decodes normally.
